// File: rtl/spectrum_bar_writer.sv
// spectrum_bar_writer: writer side of the 1-bit VGA framebuffer.
// Streams of NUM_BARS magnitudes fill a load bank; each frame_pulse latches a
// completed set into the draw bank and rasterises vertical bars, one pixel
// write per clock, row-major over the whole screen.
// Optional peak-hold markers are compiled in with `define SPECTRUM_PEAK_HOLD_EN.
module spectrum_bar_writer #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int NUM_BARS      = 32,
  parameter int BAR_GAP       = 2,
  parameter int MAG_WIDTH     = 16,
  parameter int MAG_SHIFT     = 7,
  localparam int ADDR_W       = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 bin_valid,
  output logic                 bin_ready,
  input  logic [MAG_WIDTH-1:0] bin_mag,
  input  logic                 bin_last,
  input  logic                 frame_pulse,
  output logic                 fb_wr_en,
  output logic [ADDR_W-1:0]    fb_wr_addr,
  output logic                 fb_wr_data,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam int NPIX   = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int BAR_W  = SCREEN_WIDTH / NUM_BARS;
  localparam int COL_W  = $clog2(SCREEN_WIDTH);
  localparam int HGT_W  = $clog2(SCREEN_HEIGHT + 1);
  localparam int BAR_IW = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
  localparam int CIB_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int IDX_W  = $clog2(NUM_BARS + 1);

  localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [COL_W-1:0]     COL_LAST  = COL_W'(SCREEN_WIDTH - 1);
  localparam logic [CIB_W-1:0]     CIB_LAST  = CIB_W'(BAR_W - 1);
  localparam logic [CIB_W-1:0]     CIB_LIT   = CIB_W'(BAR_W - BAR_GAP);
  localparam logic [HGT_W-1:0]     HGT_MAX   = HGT_W'(SCREEN_HEIGHT);
  localparam logic [MAG_WIDTH-1:0] MAG_SAT   = MAG_WIDTH'(SCREEN_HEIGHT);
  localparam logic [IDX_W-1:0]     IDX_END   = IDX_W'(NUM_BARS);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_DRAW} state_t;

  // Height saturates at full magnitude width so large values never alias.
  function automatic logic [HGT_W-1:0] bar_height(input logic [MAG_WIDTH-1:0] mag);
    logic [MAG_WIDTH-1:0] shifted;
    shifted = mag >> MAG_SHIFT;
    if (shifted > MAG_SAT) return HGT_MAX;
    return shifted[HGT_W-1:0];
  endfunction

  state_t                 state_q, state_d;
  logic [MAG_WIDTH-1:0]   load_bank_q [NUM_BARS];
  logic [MAG_WIDTH-1:0]   draw_bank_q [NUM_BARS];
  logic                   set_complete_q;
  logic [IDX_W-1:0]       idx_q;
  logic [HGT_W-1:0]       row_q, row_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [BAR_IW-1:0]      bar_q, bar_d;
  logic [CIB_W-1:0]       cib_q, cib_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   fb_wr_en_q, fb_wr_data_q, frame_done_q, overrun_q;
  logic [ADDR_W-1:0]      fb_wr_addr_q;
  logic                   draw_en, lit, in_cols;
  logic [HGT_W-1:0]       cur_h;
  logic                   accept;

  assign accept  = bin_valid && bin_ready;
  assign cur_h   = bar_height(draw_bank_q[bar_q]);
  assign in_cols = (cib_q < CIB_LIT);

`ifdef SPECTRUM_PEAK_HOLD_EN
  logic [HGT_W-1:0] peak_q   [NUM_BARS];
  logic [HGT_W-1:0] peak_new [NUM_BARS];

  // Per-bar decayed peak, using the height the draw bank will hold after LATCH.
  for (genvar gi = 0; gi < NUM_BARS; gi++) begin : g_peak
    logic [HGT_W-1:0] h_new, p_dec;
    assign h_new        = bar_height(set_complete_q ? load_bank_q[gi] : draw_bank_q[gi]);
    assign p_dec        = (peak_q[gi] == '0) ? '0 : peak_q[gi] - HGT_W'(1);
    assign peak_new[gi] = (h_new > p_dec) ? h_new : p_dec;
  end

  // Peak registers refresh once per frame on the LATCH cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_BARS; i++) peak_q[i] <= '0;
    end else if (state_q == S_LATCH) begin
      for (int i = 0; i < NUM_BARS; i++) peak_q[i] <= peak_new[i];
    end
  end

  assign lit = in_cols && ((row_q >= (HGT_MAX - cur_h)) ||
               ((peak_q[bar_q] != '0) && (row_q == (HGT_MAX - peak_q[bar_q]))));
`else
  assign lit = in_cols && (row_q >= (HGT_MAX - cur_h));
`endif

  // Next-state, raster counter advance and handshake ready.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    bar_d     = bar_q;
    cib_d     = cib_q;
    addr_d    = addr_q;
    bin_ready = 1'b1;
    draw_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_pulse) state_d = S_LATCH;
      end
      S_LATCH: begin
        bin_ready = 1'b0;
        row_d     = '0;
        col_d     = '0;
        bar_d     = '0;
        cib_d     = '0;
        addr_d    = '0;
        state_d   = S_DRAW;
      end
      S_DRAW: begin
        draw_en = 1'b1;
        addr_d  = addr_q + ADDR_W'(1);
        if (col_q == COL_LAST) begin
          col_d = '0;
          bar_d = '0;
          cib_d = '0;
          row_d = row_q + HGT_W'(1);
        end else begin
          col_d = col_q + COL_W'(1);
          if (cib_q == CIB_LAST) begin
            cib_d = '0;
            bar_d = bar_q + BAR_IW'(1);
          end else begin
            cib_d = cib_q + CIB_W'(1);
          end
        end
        if (addr_q == LAST_ADDR) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and raster counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      bar_q   <= '0;
      cib_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      bar_q   <= bar_d;
      cib_q   <= cib_d;
      addr_q  <= addr_d;
    end
  end

  // Registered write port, end-of-frame pulse and sticky overrun flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fb_wr_en_q   <= 1'b0;
      fb_wr_addr_q <= '0;
      fb_wr_data_q <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      fb_wr_en_q   <= draw_en;
      fb_wr_data_q <= draw_en && lit;
      if (draw_en) fb_wr_addr_q <= addr_q;
      frame_done_q <= fb_wr_en_q && (fb_wr_addr_q == LAST_ADDR);
      if (frame_pulse && (state_q != S_IDLE)) overrun_q <= 1'b1;
    end
  end

  // Load bank fill; beats past the last bar are handshaked but dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_BARS; i++) load_bank_q[i] <= '0;
      idx_q          <= '0;
      set_complete_q <= 1'b0;
    end else begin
      if (accept) begin
        if (idx_q < IDX_END) load_bank_q[idx_q[BAR_IW-1:0]] <= bin_mag;
        if (bin_last) begin
          idx_q          <= '0;
          set_complete_q <= 1'b1;
        end else if (idx_q < IDX_END) begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
      // No beat is accepted during LATCH, so the clear never races a set.
      if (state_q == S_LATCH) set_complete_q <= 1'b0;
    end
  end

  // Draw bank takes a completed set on LATCH; otherwise it keeps the last one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_BARS; i++) draw_bank_q[i] <= '0;
    end else if ((state_q == S_LATCH) && set_complete_q) begin
      for (int i = 0; i < NUM_BARS; i++) draw_bank_q[i] <= load_bank_q[i];
    end
  end

  assign fb_wr_en   = fb_wr_en_q;
  assign fb_wr_addr = fb_wr_addr_q;
  assign fb_wr_data = fb_wr_data_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/spectrum_bar_writer.md
Name: spectrum_bar_writer

Overview:
- Writer side of the 1-bit framebuffer that the VGA scan-out reads.
- Accepts a stream of NUM_BARS spectrum magnitudes and latches a complete set at each frame_pulse.
- Then rasterises vertical bars into the framebuffer, one pixel write per clock, row-major, covering all SCREEN_WIDTH*SCREEN_HEIGHT addresses.

Parameters:
- SCREEN_WIDTH, 640: visible columns.
- SCREEN_HEIGHT, 480: visible rows.
- NUM_BARS, 32: bars per frame; must divide SCREEN_WIDTH (BAR_W = SCREEN_WIDTH/NUM_BARS = 20).
- BAR_GAP, 2: unlit columns at the right edge of each bar slot; BAR_GAP < BAR_W.
- MAG_WIDTH, 16: magnitude input width, unsigned.
- MAG_SHIFT, 7: right shift that converts magnitude to bar height in pixels.

Ports:
- clk, input, 1: system/pixel clock.
- resetn, input, 1: asynchronous, active-low reset.
- bin_valid, input, 1: magnitude beat valid.
- bin_ready, output, 1: magnitude beat accepted when valid&ready.
- bin_mag, input, MAG_WIDTH: unsigned magnitude, bar 0 first.
- bin_last, input, 1: final beat of a set.
- frame_pulse, input, 1: one-cycle start-of-frame strobe (same strobe the scan-out uses).
- fb_wr_en, output, 1: framebuffer write strobe.
- fb_wr_addr, output, $clog2(SCREEN_WIDTH*SCREEN_HEIGHT): pixel address, row*SCREEN_WIDTH+col.
- fb_wr_data, output, 1: pixel value, 1 = lit.
- busy, output, 1: high while in LATCH or DRAW.
- frame_done, output, 1: one-cycle pulse after the last pixel write.
- overrun, output, 1: sticky; set when frame_pulse arrives while busy.

Behaviour:
- Reset values: all outputs 0 except bin_ready = 1. Both banks zeroed. set_complete = 0. State = IDLE.
- Load path (two banks: load bank, draw bank):
  - Each accepted beat writes load_bank[idx], then idx increments.
  - Beats with idx >= NUM_BARS are dropped but still handshaked.
  - Accepted bin_last sets set_complete and returns idx to 0.
  - Short sets leave the untouched bars at their previous load-bank values.
- State IDLE:
  - bin_ready = 1.
  - On frame_pulse, go to LATCH.
- State LATCH (1 cycle):
  - bin_ready = 0.
  - If set_complete, copy load bank into draw bank and clear set_complete; otherwise the draw bank keeps the previous set.
  - Reset row, col, bar, col_in_bar and addr counters to 0.
  - Go to DRAW.
- State DRAW:
  - bin_ready = 1; loading continues into the load bank.
  - Each cycle, register one write: fb_wr_en = 1, fb_wr_addr = addr, fb_wr_data = lit.
  - First write appears the cycle after DRAW is entered.
  - Writes are back-to-back: exactly SCREEN_WIDTH*SCREEN_HEIGHT consecutive cycles with fb_wr_en high.
- lit rule:
  - h = min(draw_bank[bar] >> MAG_SHIFT, SCREEN_HEIGHT).
  - lit = (col_in_bar < BAR_W-BAR_GAP) && (row >= SCREEN_HEIGHT-h).
  - Computed without division: col_in_bar wraps at BAR_W and increments bar; col wraps at SCREEN_WIDTH, which resets bar and increments row.
  - Saturation compare is done at MAG_WIDTH width; no truncation before saturation.
- End of DRAW:
  - After the write to addr SCREEN_WIDTH*SCREEN_HEIGHT-1, drop fb_wr_en next cycle.
  - Pulse frame_done on that same cycle, then return to IDLE.
- frame_pulse while busy (LATCH or DRAW): ignored, overrun set to 1. overrun is cleared only by reset.
- bin_valid on the LATCH cycle: not accepted (ready = 0); the source holds the beat per the valid/ready rule.
- Simultaneous bin_last acceptance in IDLE and frame_pulse: the beat completes the set in the same cycle, and LATCH on the next cycle copies it.
- Reset mid-DRAW: fb_wr_en drops immediately (asynchronous), all state clears, and the partial frame is left in the framebuffer.

Optional Feature:
- Macro SPECTRUM_PEAK_HOLD_EN.
- Enabled:
  - Per-bar peak register, reset 0.
  - In LATCH, peak = max(h_new, peak-1), floored at 0; h_new is the height from the bar's draw-bank value after any copy in that cycle.
  - In DRAW, the pixel in row SCREEN_HEIGHT-peak within the bar's lit columns is also lit when peak > 0.
- Disabled: no peak registers; lit rule exactly as above.

Test Plan:
- Reset, then frame_pulse with no bins: 307200 writes, all fb_wr_data = 0; frame_done pulses once; fb_wr_addr runs 0..307199 with no gaps.
- Load 32 beats of 1280 (h = 10), then frame_pulse: addr 470*640+0..17 = 1; cols 18,19 = 0; row 469 all 0.
- bar0 = 65535 (h saturates to 480): rows 0..479, cols 0..17 all 1; no address overflow.
- frame_pulse at write #1000 of DRAW: overrun = 1 and stays 1; the frame completes normally with 307200 writes.
- Send 5 beats with bin_last on beat 5 (values 12800): bars 0..4 h = 100, bars 5..31 keep old values; a 33-beat set without last drops beat 33.
- SPECTRUM_PEAK_HOLD_EN: bar0 h = 50 then 0 over 3 frames: marker at row 430, then 431, then 432.
